// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: valid/ready in, valid/ready out.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       OP_SEL;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] RESULT;
  logic [WIDTH-1:0] REMAINDER;
  logic             CARRY_FLAG;
  logic             ZERO_FLAG;
  logic             OVERFLOW_FLAG;
  logic             NEGATIVE_FLAG;

  modport master (
    output IN_VALID, A, B, OP_SEL, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, REMAINDER,
           CARRY_FLAG, ZERO_FLAG, OVERFLOW_FLAG, NEGATIVE_FLAG
  );

  modport slave (
    input  IN_VALID, A, B, OP_SEL, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, REMAINDER,
           CARRY_FLAG, ZERO_FLAG, OVERFLOW_FLAG, NEGATIVE_FLAG
  );
endinterface

// File: rtl/seq_alu.sv
// Clocked 16-op ALU: single-cycle logic/arith/compare/shift, iterative shift-add MUL
// and restoring DIV (one bit per cycle), result held until the consumer takes it.
//
//   state  | meaning
//   S_IDLE | ready to accept an operation
//   S_MUL  | shift-add multiply, one multiplier bit per cycle (MSB first)
//   S_DIV  | restoring divide, one quotient bit per cycle (MSB first)
//   S_DONE | result/flags valid, waiting for OUT_READY
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   remo_q, remo_d;
  logic               c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

  logic               in_ready;
  logic               load;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res_s;
  logic               c_s, v_s;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_step, quo_step;

  assign in_ready = rst_n && (state_q == S_IDLE);

  assign sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    res_s = '0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (bus.OP_SEL)
      4'h0: begin
        res_s = sum[WIDTH-1:0];
        c_s   = sum[WIDTH];
        v_s   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'h1: begin
        res_s = diff[WIDTH-1:0];
        c_s   = diff[WIDTH];
        v_s   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'h4: res_s = bus.A & bus.B;
      4'h5: res_s = bus.A | bus.B;
      4'h6: res_s = bus.A ^ bus.B;
      4'h7: res_s = ~bus.A;
      4'h8: res_s = WIDTH'(bus.A == bus.B);
      4'h9: res_s = WIDTH'(bus.A != bus.B);
      4'hA: res_s = WIDTH'(bus.A > bus.B);
      4'hB: res_s = WIDTH'(bus.A < bus.B);
      4'hC: res_s = WIDTH'(bus.A >= bus.B);
      4'hD: res_s = WIDTH'(bus.A <= bus.B);
      4'hE: begin
        res_s = {bus.A[WIDTH-2:0], 1'b0};
        c_s   = bus.A[WIDTH-1];
      end
      4'hF: begin
        res_s = {1'b0, bus.A[WIDTH-1:1]};
        c_s   = bus.A[0];
      end
      default: res_s = '0;
    endcase
  end

  // a_q doubles as multiplier shifter (MUL) and dividend-in / quotient-out shifter (DIV).
  assign prod_step = {prod_q[2*WIDTH-2:0], 1'b0}
                   + (a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : {(2*WIDTH){1'b0}});
  assign trial     = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
  assign rem_step  = trial[WIDTH] ? {rem_q[WIDTH-2:0], a_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_step  = {a_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    remo_d  = remo_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.IN_VALID && in_ready) begin
          a_d    = bus.A;
          b_d    = bus.B;
          rem_d  = '0;
          prod_d = '0;
          cnt_d  = CW'(WIDTH - 1);
          case (bus.OP_SEL)
            4'h2: state_d = S_MUL;
            4'h3: begin
              if (bus.B != '0) begin
                state_d = S_DIV;
              end else begin
                load    = 1'b1;
                res_d   = '1;
                remo_d  = bus.A;
                c_d     = 1'b0;
                v_d     = 1'b1;
                state_d = S_DONE;
              end
            end
            default: begin
              load    = 1'b1;
              res_d   = res_s;
              remo_d  = '0;
              c_d     = c_s;
              v_d     = v_s;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        prod_d = prod_step;
        a_d    = {a_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          load    = 1'b1;
          res_d   = prod_step[WIDTH-1:0];
          remo_d  = '0;
          c_d     = |prod_step[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        a_d   = quo_step;
        if (cnt_q == '0) begin
          load    = 1'b1;
          res_d   = quo_step;
          remo_d  = rem_step;
          c_d     = 1'b0;
          v_d     = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Z/N only follow a freshly produced result so they read 0 out of reset.
    if (load) begin
      z_d = (res_d == '0);
      n_d = res_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      remo_q  <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      remo_q  <= remo_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign bus.IN_READY      = in_ready;
  assign bus.OUT_VALID     = (state_q == S_DONE);
  assign bus.RESULT        = res_q;
  assign bus.REMAINDER     = remo_q;
  assign bus.CARRY_FLAG    = c_q;
  assign bus.ZERO_FLAG     = z_q;
  assign bus.OVERFLOW_FLAG = v_q;
  assign bus.NEGATIVE_FLAG = n_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(8))  if8 ();
  seq_alu_if #(.WIDTH(16)) if16 ();

  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        c, v, z, n;
  } exp_t;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int w, logic [3:0] op, longint a, longint b);
    exp_t   e;
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sa   = (a >= half) ? a - 2 * half : a;
    longint sb   = (b >= half) ? b - 2 * half : b;
    longint t    = 0;
    e.rem = '0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      4'h0: begin t = a + b; e.c = (t > m); e.v = (sa + sb > half - 1) || (sa + sb < -half); end
      4'h1: begin t = a - b; e.c = (a < b); e.v = (sa - sb > half - 1) || (sa - sb < -half); end
      4'h2: begin t = a * b; e.c = ((t >> w) != 0); end
      4'h3: begin
        if (b == 0) begin t = m; e.rem = 16'(a); e.v = 1'b1; end
        else begin t = a / b; e.rem = 16'(a % b); end
      end
      4'h4: t = a & b;
      4'h5: t = a | b;
      4'h6: t = a ^ b;
      4'h7: t = ~a;
      4'h8: t = longint'(a == b);
      4'h9: t = longint'(a != b);
      4'hA: t = longint'(a > b);
      4'hB: t = longint'(a < b);
      4'hC: t = longint'(a >= b);
      4'hD: t = longint'(a <= b);
      4'hE: begin t = a << 1; e.c = ((a >> (w - 1)) & 1) != 0; end
      default: begin t = a >> 1; e.c = (a & 1) != 0; end
    endcase
    e.res = 16'(t & m);
    e.z   = (e.res == 0);
    e.n   = ((longint'(e.res) >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  function automatic logic rdy(bit w16);
    return w16 ? if16.IN_READY : if8.IN_READY;
  endfunction

  function automatic logic ov(bit w16);
    return w16 ? if16.OUT_VALID : if8.OUT_VALID;
  endfunction

  // {res, rem, c, v, z, n}
  function automatic logic [35:0] outs(bit w16);
    if (w16)
      return {if16.RESULT, if16.REMAINDER, if16.CARRY_FLAG, if16.OVERFLOW_FLAG,
              if16.ZERO_FLAG, if16.NEGATIVE_FLAG};
    return {8'h0, if8.RESULT, 8'h0, if8.REMAINDER, if8.CARRY_FLAG, if8.OVERFLOW_FLAG,
            if8.ZERO_FLAG, if8.NEGATIVE_FLAG};
  endfunction

  task automatic put(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    if8.OP_SEL  = op;  if8.A  = a[7:0]; if8.B  = b[7:0];
    if16.OP_SEL = op;  if16.A = a;      if16.B = b;
  endtask

  task automatic set_valid(bit w16, logic v);
    if (w16) if16.IN_VALID = v;
    else     if8.IN_VALID  = v;
  endtask

  task automatic set_oready(logic r);
    if8.OUT_READY  = r;
    if16.OUT_READY = r;
  endtask

  task automatic run_op(bit w16, logic [3:0] op, logic [15:0] a, logic [15:0] b, int hold);
    int          w = w16 ? 16 : 8;
    int          g = 0;
    int          lat = 1;
    int          exp_lat;
    exp_t        e;
    logic [35:0] o;
    if (!w16) begin a[15:8] = '0; b[15:8] = '0; end
    e = model(w, op, longint'(a), longint'(b));
    exp_lat = (op == 4'h2 || (op == 4'h3 && b != 0)) ? w + 1 : 1;
    @(negedge clk);
    while (!rdy(w16) && g < 50) begin @(negedge clk); g++; end
    chk("in_ready_before", rdy(w16), 1);
    put(op, a, b);
    set_valid(w16, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(w16, 1'b0);
    put(4'($urandom), 16'($urandom), 16'($urandom));
    while (!ov(w16) && lat < 100) begin @(negedge clk); lat++; end
    chk($sformatf("latency op%0h", op), lat, exp_lat);
    o = outs(w16);
    chk($sformatf("result op%0h a=%0h b=%0h", op, a, b), o[35:20], e.res);
    chk($sformatf("remainder op%0h", op), o[19:4], e.rem);
    chk($sformatf("carry op%0h", op), o[3], e.c);
    chk($sformatf("overflow op%0h", op), o[2], e.v);
    chk($sformatf("zero op%0h", op), o[1], e.z);
    chk($sformatf("negative op%0h", op), o[0], e.n);
    for (int i = 0; i < hold; i++) begin
      put(4'($urandom), 16'($urandom), 16'($urandom));
      set_valid(w16, 1'b1);
      @(negedge clk);
      chk("hold_outputs", outs(w16), o);
      chk("hold_out_valid", ov(w16), 1);
      chk("hold_in_ready", rdy(w16), 0);
    end
    set_valid(w16, 1'b0);
    set_oready(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_oready(1'b0);
    chk("out_valid_after_take", ov(w16), 0);
    chk("in_ready_after_take", rdy(w16), 1);
  endtask

  task automatic back_to_back(int n);
    exp_t        q[$];
    exp_t        e;
    logic [3:0]  op;
    logic [7:0]  a, b;
    logic        r;
    int          got = 0;
    set_oready(1'b1);
    @(negedge clk);
    op = 4'($urandom_range(4, 15)); a = 8'($urandom); b = 8'($urandom);
    put(op, {8'h0, a}, {8'h0, b});
    set_valid(0, 1'b1);
    for (int c = 0; c < 2 * n; c++) begin
      r = if8.IN_READY;
      @(posedge clk);
      @(negedge clk);
      if (r) begin
        q.push_back(model(8, op, longint'(a), longint'(b)));
        op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(4, 15));
        a = 8'($urandom); b = 8'($urandom);
        put(op, {8'h0, a}, {8'h0, b});
      end
      if (if8.OUT_VALID) begin
        got++;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_result", if8.RESULT, e.res);
          chk("b2b_carry", if8.CARRY_FLAG, e.c);
        end else begin
          chk("b2b_unexpected_result", 1, 0);
        end
      end
    end
    set_valid(0, 1'b0);
    set_oready(1'b0);
    chk("b2b_result_count", got, n);
  endtask

  task automatic reset_mid_mul();
    bit seen = 1'b0;
    @(negedge clk);
    put(4'h2, 16'h0012, 16'h0010);
    set_valid(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", outs(0), 36'h0);
    chk("rst_out_valid", if8.OUT_VALID, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", if8.IN_READY, 1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (if8.OUT_VALID) seen = 1'b1;
    end
    chk("rst_no_out_valid", seen, 0);
  endtask

  initial begin
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    set_oready(1'b0);
    put(4'h0, 16'h0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs_w8", outs(0), 36'h0);
    chk("reset_outputs_w16", outs(1), 36'h0);
    chk("reset_out_valid", if8.OUT_VALID, 0);
    chk("reset_in_ready_low", if8.IN_READY, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_w8", if8.IN_READY, 1);
    chk("release_in_ready_w16", if16.IN_READY, 1);

    run_op(0, 4'h0, 16'h7F, 16'h01, 0);
    run_op(0, 4'h0, 16'hFF, 16'h01, 0);
    run_op(0, 4'h1, 16'h05, 16'h07, 0);
    run_op(0, 4'h2, 16'h12, 16'h10, 5);
    run_op(0, 4'h3, 16'h64, 16'h07, 0);
    run_op(0, 4'h3, 16'h33, 16'h00, 1);
    run_op(0, 4'hA, 16'h80, 16'h7F, 0);
    run_op(0, 4'hF, 16'h81, 16'h00, 0);
    run_op(0, 4'hE, 16'h81, 16'h00, 0);
    run_op(0, 4'h2, 16'hFF, 16'hFF, 0);
    run_op(0, 4'h3, 16'hFF, 16'h01, 0);

    back_to_back(8);

    reset_mid_mul();
    run_op(0, 4'h0, 16'h3C, 16'h45, 0);

    run_op(1, 4'h2, 16'h1234, 16'h0100, 2);
    run_op(1, 4'h2, 16'hFFFF, 16'hFFFF, 0);
    run_op(1, 4'h3, 16'hBEEF, 16'h0123, 0);
    run_op(1, 4'h3, 16'h1234, 16'h0000, 0);
    run_op(1, 4'h0, 16'h7FFF, 16'h0001, 0);

    for (int i = 0; i < 40; i++)
      run_op(0, 4'($urandom), 16'($urandom),
             ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom), $urandom_range(0, 2));
    for (int i = 0; i < 20; i++)
      run_op(1, 4'($urandom), 16'($urandom),
             ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom), $urandom_range(0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
